// File: rtl/reset_gen.sv
// reset_gen: power-on, push-button, software and optional watchdog reset sequencer.
// The watchdog is compiled in only when RESET_GEN_WDT_EN is defined.
module reset_gen #(
    parameter int POR_CYCLES      = 31,
    parameter int NUM_BTN         = 1,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int STRETCH_CYCLES  = 16,
    parameter int WDT_CYCLES      = 12000000
) (
    input  logic               clk,
    input  logic               reset_n_i,
    input  logic [NUM_BTN-1:0] btn_n_i,
    input  logic               sw_reset_req_i,
    input  logic               wdt_kick_i,
    input  logic               cause_clr_i,
    output logic               reset_o,
    output logic [3:0]         cause_o
);

    // state   | meaning
    // POR     | reset_n_i released, counting POR_CYCLES after sync release
    // RUN     | system out of reset, watching triggers
    // HOLD    | a debounced button is pressed, waiting for all released
    // STRETCH | minimum-length tail after any internal trigger

    localparam int POR_W = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int STR_W = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;

    localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STR_W-1:0] STR_LAST = STR_W'(STRETCH_CYCLES - 1);

    typedef enum logic [1:0] {
        POR     = 2'd0,
        RUN     = 2'd1,
        HOLD    = 2'd2,
        STRETCH = 2'd3
    } state_t;

    state_t             state;
    logic [1:0]         rst_sync;
    logic [NUM_BTN-1:0] btn_meta;
    logic [NUM_BTN-1:0] btn_sync;
    logic [NUM_BTN-1:0] btn_deb;
    logic [DEB_W-1:0]   deb_cnt [NUM_BTN];
    logic [POR_W-1:0]   por_cnt;
    logic [STR_W-1:0]   str_cnt;
    logic               btn_press;
    logic               btn_idle;
    logic               wdt_fire;
    logic [3:0]         cause_set;

    // Release of reset_n_i is synchronised; assertion stays asynchronous.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            btn_meta <= '1;
            btn_sync <= '1;
            btn_deb  <= '1;
            for (int i = 0; i < NUM_BTN; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            btn_meta <= btn_n_i;
            btn_sync <= btn_meta;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (btn_sync[i] == btn_deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    btn_deb[i] <= btn_sync[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign btn_press = ~(&btn_deb);
    assign btn_idle  = &btn_deb;

`ifdef RESET_GEN_WDT_EN
    localparam int WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt;

    assign wdt_fire = (state == RUN) && !wdt_kick_i && (wdt_cnt == WDT_LAST);

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wdt_cnt <= '0;
        end else if ((state != RUN) || wdt_kick_i) begin
            wdt_cnt <= '0;
        end else if (wdt_cnt != WDT_LAST) begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end
    end
`else
    localparam int unused_wdt_cycles = WDT_CYCLES;
    logic unused_kick;

    assign unused_kick = wdt_kick_i;
    assign wdt_fire    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= POR;
            reset_o <= 1'b1;
            por_cnt <= POR_LAST;
            str_cnt <= STR_LAST;
        end else begin
            case (state)
                POR: begin
                    reset_o <= 1'b1;
                    if (rst_sync[1]) begin
                        if (por_cnt == '0) begin
                            state   <= RUN;
                            reset_o <= 1'b0;
                        end else begin
                            por_cnt <= por_cnt - 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Button wins over software/watchdog so it is held for its full press.
                    if (btn_press) begin
                        state   <= HOLD;
                        reset_o <= 1'b1;
                    end else if (sw_reset_req_i || wdt_fire) begin
                        state   <= STRETCH;
                        reset_o <= 1'b1;
                        str_cnt <= STR_LAST;
                    end
                end
                HOLD: begin
                    reset_o <= 1'b1;
                    if (btn_idle) begin
                        state   <= STRETCH;
                        str_cnt <= STR_LAST;
                    end
                end
                STRETCH: begin
                    if (btn_press) begin
                        state   <= HOLD;
                        reset_o <= 1'b1;
                    end else if (str_cnt == '0) begin
                        state   <= RUN;
                        reset_o <= 1'b0;
                    end else begin
                        str_cnt <= str_cnt - 1'b1;
                        reset_o <= 1'b1;
                    end
                end
                default: begin
                    state   <= POR;
                    reset_o <= 1'b1;
                    por_cnt <= POR_LAST;
                end
            endcase
        end
    end

    always_comb begin
        cause_set = 4'b0000;
        if (state == RUN) begin
            cause_set[1] = btn_press;
            cause_set[2] = sw_reset_req_i;
            cause_set[3] = wdt_fire;
        end
    end

    // Only reset_n_i touches the cause register, so it survives internal resets.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cause_o <= 4'b0001;
        end else begin
            cause_o <= (cause_clr_i ? 4'b0000 : cause_o) | cause_set;
        end
    end

endmodule

// File: tb/tb_reset_gen.sv
// Directed bench for reset_gen: POR, debounce, software, watchdog, cause and async reset.
`timescale 1ns/1ps
module tb_reset_gen;

    localparam int NB = 2;

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic [NB-1:0] btn_n_i;
    logic          sw_reset_req_i;
    logic          kick_man;
    logic          kick_auto;
    logic          auto_en;
    logic          wdt_kick_i;
    logic          cause_clr_i;
    logic          reset_o;
    logic [3:0]    cause_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign wdt_kick_i = kick_man | kick_auto;

    reset_gen #(
        .POR_CYCLES     (31),
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(8),
        .STRETCH_CYCLES (16),
        .WDT_CYCLES     (100)
    ) dut (
        .clk           (clk),
        .reset_n_i     (reset_n_i),
        .btn_n_i       (btn_n_i),
        .sw_reset_req_i(sw_reset_req_i),
        .wdt_kick_i    (wdt_kick_i),
        .cause_clr_i   (cause_clr_i),
        .reset_o       (reset_o),
        .cause_o       (cause_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic watch(input int n, output logic any_hi, output logic any_lo);
        any_hi = 1'b0;
        any_lo = 1'b0;
        repeat (n) begin
            tick(1);
            any_hi |= reset_o;
            any_lo |= ~reset_o;
        end
    endtask

    // Background kicker keeps the watchdog quiet while other features are exercised.
    initial begin
        int k;
        k = 0;
        kick_auto = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            k = (k + 1) % 20;
            kick_auto = auto_en && (k == 0);
        end
    end

    initial begin
        logic hi, lo, any;
        reset_n_i      = 1'b0;
        btn_n_i        = '1;
        sw_reset_req_i = 1'b0;
        kick_man       = 1'b0;
        cause_clr_i    = 1'b0;
        auto_en        = 1'b1;
        any            = 1'b0;

        tick(3);
        check_val("rst_reset_o", reset_o, 1);
        check_val("rst_cause", cause_o, 4'b0001);

        reset_n_i = 1'b1;
        watch(32, hi, lo);
        check_val("por_held_32", lo, 0);
        tick(1);
        check_val("por_fall_33", reset_o, 0);
        check_val("por_cause", cause_o, 4'b0001);

        btn_n_i[0] = 1'b0;
        tick(5);
        btn_n_i[0] = 1'b1;
        watch(30, hi, lo);
        check_val("glitch_no_reset", hi, 0);
        check_val("glitch_cause", cause_o, 4'b0001);

        btn_n_i[0] = 1'b0;
        tick(10);
        check_val("btn_low_edge10", reset_o, 0);
        tick(1);
        check_val("btn_high_edge11", reset_o, 1);
        watch(9, hi, lo);
        check_val("btn_held", lo, 0);
        btn_n_i[0] = 1'b1;
        watch(26, hi, lo);
        check_val("btn_release_tail", lo, 0);
        tick(1);
        check_val("btn_release_fall", reset_o, 0);
        check_val("btn_cause", cause_o, 4'b0011);

        sw_reset_req_i = 1'b1;
        tick(1);
        sw_reset_req_i = 1'b0;
        check_val("sw_next_cycle", reset_o, 1);
        tick(3);
        sw_reset_req_i = 1'b1;
        tick(1);
        sw_reset_req_i = 1'b0;
        watch(11, hi, lo);
        check_val("sw_stretch_held", lo, 0);
        tick(1);
        check_val("sw_no_extend", reset_o, 0);
        check_val("sw_cause", cause_o, 4'b0111);

        cause_clr_i    = 1'b1;
        sw_reset_req_i = 1'b1;
        tick(1);
        cause_clr_i    = 1'b0;
        sw_reset_req_i = 1'b0;
        check_val("clr_sw_set_wins", cause_o, 4'b0100);
        tick(20);
        check_val("clr_sw_back_run", reset_o, 0);
        cause_clr_i = 1'b1;
        tick(1);
        cause_clr_i = 1'b0;
        check_val("clr_alone", cause_o, 4'b0000);

        btn_n_i[1] = 1'b0;
        tick(10);
        sw_reset_req_i = 1'b1;
        tick(1);
        sw_reset_req_i = 1'b0;
        check_val("both_reset", reset_o, 1);
        check_val("both_cause", cause_o, 4'b0110);
        watch(30, hi, lo);
        check_val("both_is_hold", lo, 0);
        btn_n_i[1] = 1'b1;
        watch(26, hi, lo);
        check_val("both_tail", lo, 0);
        tick(1);
        check_val("both_fall", reset_o, 0);

        sw_reset_req_i = 1'b1;
        tick(1);
        sw_reset_req_i = 1'b0;
        btn_n_i[0] = 1'b0;
        watch(40, hi, lo);
        check_val("stretch_to_hold", lo, 0);
        btn_n_i[0] = 1'b1;
        watch(26, hi, lo);
        check_val("stretch_hold_tail", lo, 0);
        tick(1);
        check_val("stretch_hold_fall", reset_o, 0);

        reset_n_i = 1'b0;
        #1;
        check_val("async_from_run", reset_o, 1);
        check_val("async_cause", cause_o, 4'b0001);
        tick(3);
        reset_n_i = 1'b1;
        tick(33);
        check_val("rerun_por_1", reset_o, 0);

        sw_reset_req_i = 1'b1;
        tick(1);
        sw_reset_req_i = 1'b0;
        tick(5);
        reset_n_i = 1'b0;
        #1;
        check_val("mid_stretch_reset_o", reset_o, 1);
        tick(3);
        reset_n_i = 1'b1;
        watch(32, hi, lo);
        check_val("mid_stretch_por_held", lo, 0);
        tick(1);
        check_val("mid_stretch_por_fall", reset_o, 0);
        check_val("mid_stretch_cause", cause_o, 4'b0001);

`ifdef RESET_GEN_WDT_EN
        auto_en     = 1'b0;
        cause_clr_i = 1'b1;
        tick(1);
        cause_clr_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            kick_man = 1'b1;
            tick(1);
            kick_man = 1'b0;
            watch(49, hi, lo);
            any |= hi;
        end
        check_val("wdt_kicked_no_reset", any, 0);
        watch(50, hi, lo);
        check_val("wdt_before_timeout", hi, 0);
        tick(1);
        check_val("wdt_timeout", reset_o, 1);
        check_val("wdt_cause", cause_o, 4'b1000);
        tick(20);
        check_val("wdt_back_run", reset_o, 0);
`else
        auto_en = 1'b0;
        watch(300, hi, lo);
        check_val("nowdt_no_reset", hi, 0);
        check_val("nowdt_cause3", cause_o[3], 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
